pipeline_sequencer: RTL and testbench

- Central sequencing controller for the 5-stage pipeline (fetch, decode, execute, memory, writeback).
- Combines three inputs into per-register write-enable and flush controls:
  - the combinational data-hazard stall request;
  - the execute-stage branch resolution;
  - the memory-stage ready/wait handshake.
- Owns halt/single-step debug sequencing and saturating stall/flush performance counters.

---
 rtl/pipeline_sequencer_if.sv | 39 +++
 rtl/pipeline_sequencer.sv | 135 +++++++++++++
 tb/tb_pipeline_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the pipeline sequencer and the surrounding datapath:
// hazard/branch/memory/debug requests in, per-register enables and counters out.
interface pipeline_sequencer_if #(
    parameter int unsigned COUNT_W = 16
);
    logic               i_hazard_stall;
    logic               i_branch_taken;
    logic               i_mem_req;
    logic               i_mem_ready;
    logic               i_halt;
    logic               i_debug_step;
    logic               i_resume;
    logic               o_pc_we;
    logic               o_fd_we;
    logic               o_fd_flush;
    logic               o_de_we;
    logic               o_de_flush;
    logic               o_em_we;
    logic               o_mw_we;
    logic               o_mw_flush;
    logic               o_halted;
    logic [1:0]         o_state;
    logic [COUNT_W-1:0] o_stall_count;
    logic [COUNT_W-1:0] o_flush_count;

    modport master (
        output i_hazard_stall, i_branch_taken, i_mem_req, i_mem_ready,
               i_halt, i_debug_step, i_resume,
        input  o_pc_we, o_fd_we, o_fd_flush, o_de_we, o_de_flush, o_em_we,
               o_mw_we, o_mw_flush, o_halted, o_state, o_stall_count, o_flush_count
    );

    modport slave (
        input  i_hazard_stall, i_branch_taken, i_mem_req, i_mem_ready,
               i_halt, i_debug_step, i_resume,
        output o_pc_we, o_fd_we, o_fd_flush, o_de_we, o_de_flush, o_em_we,
               o_mw_we, o_mw_flush, o_halted, o_state, o_stall_count, o_flush_count
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// 5-stage pipeline sequencing controller: stall/flush enables, halt/single-step
// debug sequencing and saturating stall/flush performance counters.
module pipeline_sequencer #(
    parameter int unsigned COUNT_W = 16
) (
    input logic                 i_clk,
    input logic                 i_reset,
    pipeline_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalt    = 2'd2,
        StStep    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    logic [COUNT_W-1:0] stall_q, flush_q;

    logic mem_stall, mem_stall_act, stall_inc, flush_inc;
    logic pc_we, fd_we, fd_flush, de_we, de_flush, em_we, mw_we, mw_flush;

    assign mem_stall = bus.i_mem_req & ~bus.i_mem_ready;

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        mem_stall_act = 1'b0;
        flush_inc     = 1'b0;
        stall_inc     = 1'b0;
        pc_we         = 1'b1;
        fd_we         = 1'b1;
        fd_flush      = 1'b0;
        de_we         = 1'b1;
        de_flush      = 1'b0;
        em_we         = 1'b1;
        mw_we         = 1'b1;
        mw_flush      = 1'b0;

        unique case (state_q)
            StRun, StStep: begin
                if (mem_stall) begin
                    mem_stall_act = 1'b1;
                    state_d       = StMemWait;
                    ret_d         = (state_q == StStep) ? StHalt : StRun;
                end else begin
                    // Taken branch outranks a hazard: the stalled instruction is squashed anyway.
                    if (bus.i_branch_taken) begin
                        fd_flush  = 1'b1;
                        de_flush  = 1'b1;
                        flush_inc = 1'b1;
                    end else if (bus.i_hazard_stall) begin
                        pc_we     = 1'b0;
                        fd_we     = 1'b0;
                        de_flush  = 1'b1;
                        stall_inc = 1'b1;
                    end
                    if (state_q == StStep || bus.i_halt) begin
                        state_d = StHalt;
                    end
                end
            end
            StHalt: begin
                if (mem_stall) begin
                    mem_stall_act = 1'b1;
                    state_d       = StMemWait;
                    ret_d         = StHalt;
                end else begin
                    pc_we    = 1'b0;
                    fd_we    = 1'b0;
                    de_flush = 1'b1;
                    if (bus.i_resume) begin
                        state_d = StRun;
                    end else if (bus.i_debug_step) begin
                        state_d = StStep;
                    end
                end
            end
            StMemWait: begin
                // Hazard and branch inputs are ignored on the release cycle.
                if (!bus.i_mem_ready) begin
                    mem_stall_act = 1'b1;
                end else begin
                    state_d = ret_q;
                end
            end
            default: state_d = StRun;
        endcase

        if (mem_stall_act) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            fd_flush  = 1'b0;
            de_we     = 1'b0;
            de_flush  = 1'b0;
            em_we     = 1'b0;
            mw_flush  = 1'b1;
            stall_inc = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StRun;
            ret_q   <= StRun;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            if (stall_inc && stall_q != '1) begin
                stall_q <= stall_q + COUNT_W'(1);
            end
            if (flush_inc && flush_q != '1) begin
                flush_q <= flush_q + COUNT_W'(1);
            end
        end
    end

    assign bus.o_pc_we       = pc_we;
    assign bus.o_fd_we       = fd_we;
    assign bus.o_fd_flush    = fd_flush;
    assign bus.o_de_we       = de_we;
    assign bus.o_de_flush    = de_flush;
    assign bus.o_em_we       = em_we;
    assign bus.o_mw_we       = mw_we;
    assign bus.o_mw_flush    = mw_flush;
    assign bus.o_halted      = (state_q == StHalt);
    assign bus.o_state       = state_q;
    assign bus.o_stall_count = stall_q;
    assign bus.o_flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a
// randomized run against a table-driven behavioural model.
module tb_pipeline_sequencer;

    // Control vector order: {pc_we, fd_we, fd_flush, de_we, de_flush, em_we, mw_we, mw_flush}
    localparam logic [7:0] CtlNorm  = 8'b1101_0110;
    localparam logic [7:0] CtlMem   = 8'b0000_0011;
    localparam logic [7:0] CtlBr    = 8'b1111_1110;
    localparam logic [7:0] CtlHaz   = 8'b0001_1110;
    localparam logic [7:0] CtlDrain = 8'b0001_1110;

    localparam int SRun = 0, SMem = 1, SHalt = 2, SStep = 3;
    localparam int Max16 = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_sequencer_if #(.COUNT_W(16)) bus ();
    pipeline_sequencer_if #(.COUNT_W(4))  bus_sat ();

    pipeline_sequencer #(.COUNT_W(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    pipeline_sequencer #(.COUNT_W(4)) dut_sat (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_sat.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int m_state, m_ret, m_stall, m_flush;

    function automatic logic [7:0] dut_ctl();
        return {bus.o_pc_we, bus.o_fd_we, bus.o_fd_flush, bus.o_de_we, bus.o_de_flush,
                bus.o_em_we, bus.o_mw_we, bus.o_mw_flush};
    endfunction

    task automatic set_in(input logic h, input logic b, input logic mr, input logic mrdy,
                          input logic halt, input logic step, input logic res);
        bus.i_hazard_stall     = h;    bus_sat.i_hazard_stall = h;
        bus.i_branch_taken     = b;    bus_sat.i_branch_taken = b;
        bus.i_mem_req          = mr;   bus_sat.i_mem_req      = mr;
        bus.i_mem_ready        = mrdy; bus_sat.i_mem_ready    = mrdy;
        bus.i_halt             = halt; bus_sat.i_halt         = halt;
        bus.i_debug_step       = step; bus_sat.i_debug_step   = step;
        bus.i_resume           = res;  bus_sat.i_resume       = res;
    endtask

    task automatic model_reset();
        m_state = SRun;
        m_ret   = SRun;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Picks the action the rules call for, then reads its enables from the table above.
    task automatic model_eval(output logic [7:0] ctl, output int nstate, output int nret,
                              output int dstall, output int dflush);
        logic memst;
        memst  = bus.i_mem_req && !bus.i_mem_ready;
        nstate = m_state;
        nret   = m_ret;
        dstall = 0;
        dflush = 0;
        ctl    = CtlNorm;
        if (m_state == SRun || m_state == SStep) begin
            if (memst) begin
                ctl = CtlMem; dstall = 1; nstate = SMem;
                nret = (m_state == SStep) ? SHalt : SRun;
            end else begin
                if (bus.i_branch_taken)      begin ctl = CtlBr;  dflush = 1; end
                else if (bus.i_hazard_stall) begin ctl = CtlHaz; dstall = 1; end
                if (m_state == SStep) nstate = SHalt;
                else nstate = bus.i_halt ? SHalt : SRun;
            end
        end else if (m_state == SHalt) begin
            if (memst) begin
                ctl = CtlMem; dstall = 1; nstate = SMem; nret = SHalt;
            end else begin
                ctl = CtlDrain;
                nstate = bus.i_resume ? SRun : (bus.i_debug_step ? SStep : SHalt);
            end
        end else begin
            if (!bus.i_mem_ready) begin ctl = CtlMem; dstall = 1; end
            else nstate = m_ret;
        end
    endtask

    task automatic tick();
        logic [7:0] ctl;
        int ns, nr, ds, df;
        model_eval(ctl, ns, nr, ds, df);
        @(posedge clk);
        m_state = ns;
        m_ret   = nr;
        m_stall = (m_stall + ds > Max16) ? Max16 : m_stall + ds;
        m_flush = (m_flush + df > Max16) ? Max16 : m_flush + df;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (dut_ctl() !== CtlNorm) begin
            n_fail++; $display("FAIL reset_ctl: got %b want %b", dut_ctl(), CtlNorm);
        end
        n_cmp++;
        if (bus.o_state !== 2'd0 || bus.o_halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got st=%0d halted=%b want 0/0",
                               bus.o_state, bus.o_halted);
        end
        n_cmp++;
        if (bus.o_stall_count !== 16'd0 || bus.o_flush_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0",
                               bus.o_stall_count, bus.o_flush_count);
        end
        rst = 1'b0;
        model_reset();
        tick();
        n_cmp++;
        if (dut_ctl() !== CtlNorm || bus.o_state !== 2'd0) begin
            n_fail++; $display("FAIL idle_after_reset: got ctl=%b st=%0d want %b/0",
                               dut_ctl(), bus.o_state, CtlNorm);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        set_in(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (dut_ctl() !== CtlHaz) begin
                n_fail++; $display("FAIL hazard_ctl[%0d]: got %b want %b", i, dut_ctl(), CtlHaz);
            end
            tick();
        end
        set_in(0, 0, 0, 1, 0, 0, 0);
        #1;
        n_cmp++;
        if (bus.o_stall_count !== 16'd3) begin
            n_fail++; $display("FAIL hazard_count: got %0d want 3", bus.o_stall_count);
        end
        tick();
    endtask

    task automatic test_branch_vs_hazard();
        do_reset();
        set_in(1, 1, 0, 1, 0, 0, 0);
        #1;
        n_cmp++;
        if (dut_ctl() !== CtlBr) begin
            n_fail++; $display("FAIL branch_ctl: got %b want %b", dut_ctl(), CtlBr);
        end
        tick();
        set_in(0, 0, 0, 1, 0, 0, 0);
        #1;
        n_cmp++;
        if (bus.o_flush_count !== 16'd1 || bus.o_stall_count !== 16'd0) begin
            n_fail++; $display("FAIL branch_counts: got flush=%0d stall=%0d want 1/0",
                               bus.o_flush_count, bus.o_stall_count);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        int in_wait;
        in_wait = 0;
        do_reset();
        set_in(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.o_state == 2'd1) in_wait++;
            n_cmp++;
            if (bus.o_mw_flush !== 1'b1 || dut_ctl() !== CtlMem) begin
                n_fail++; $display("FAIL mem_stall_ctl[%0d]: got %b want %b", i, dut_ctl(), CtlMem);
            end
            tick();
        end
        set_in(1, 1, 1, 1, 0, 0, 0);
        #1;
        if (bus.o_state == 2'd1) in_wait++;
        n_cmp++;
        if (dut_ctl() !== CtlNorm || bus.o_stall_count !== 16'd4) begin
            n_fail++; $display("FAIL mem_release: got ctl=%b stall=%0d want %b/4",
                               dut_ctl(), bus.o_stall_count, CtlNorm);
        end
        tick();
        set_in(0, 0, 0, 1, 0, 0, 0);
        #1;
        n_cmp++;
        if (bus.o_state !== 2'd0 || in_wait != 4 || bus.o_flush_count !== 16'd0) begin
            n_fail++; $display("FAIL mem_return: got st=%0d wait_cycles=%0d flush=%0d want 0/4/0",
                               bus.o_state, in_wait, bus.o_flush_count);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_in(0, 0, 1, 0, 0, 0, 0);
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_state !== 2'd0 || bus.o_stall_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid_wait: got st=%0d stall=%0d want 0/0",
                               bus.o_state, bus.o_stall_count);
        end
        rst = 1'b0;
        model_reset();
        set_in(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_halt_step();
        do_reset();
        set_in(0, 0, 0, 1, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 0, 0, 0);
        #1;
        n_cmp++;
        if (bus.o_state !== 2'd2 || bus.o_halted !== 1'b1 || bus.o_pc_we !== 1'b0) begin
            n_fail++; $display("FAIL halt_enter: got st=%0d halted=%b pc_we=%b want 2/1/0",
                               bus.o_state, bus.o_halted, bus.o_pc_we);
        end
        tick();
        set_in(0, 0, 0, 1, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 1, 0, 0, 0);
        #1;
        n_cmp++;
        if (bus.o_state !== 2'd3 || bus.o_pc_we !== 1'b1 || bus.o_halted !== 1'b0) begin
            n_fail++; $display("FAIL step_cycle: got st=%0d pc_we=%b halted=%b want 3/1/0",
                               bus.o_state, bus.o_pc_we, bus.o_halted);
        end
        tick();
        #1;
        n_cmp++;
        if (bus.o_state !== 2'd2) begin
            n_fail++; $display("FAIL step_return: got st=%0d want 2", bus.o_state);
        end
        set_in(0, 0, 0, 1, 0, 1, 1);
        tick();
        set_in(0, 0, 0, 1, 0, 0, 0);
        #1;
        n_cmp++;
        if (bus.o_state !== 2'd0 || bus.o_stall_count !== 16'd0) begin
            n_fail++; $display("FAIL resume: got st=%0d stall=%0d want 0/0",
                               bus.o_state, bus.o_stall_count);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        #1;
        n_cmp++;
        if (bus_sat.o_stall_count !== 4'd15 || bus.o_stall_count !== 16'd20) begin
            n_fail++; $display("FAIL saturate: got w4=%0d w16=%0d want 15/20",
                               bus_sat.o_stall_count, bus.o_stall_count);
        end
        tick();
        #1;
        n_cmp++;
        if (bus_sat.o_stall_count !== 4'd15) begin
            n_fail++; $display("FAIL saturate_hold: got %0d want 15", bus_sat.o_stall_count);
        end
        set_in(0, 0, 0, 1, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        logic [7:0] ctl;
        int ns, nr, ds, df;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
                   $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 7) == 0);
            #1;
            model_eval(ctl, ns, nr, ds, df);
            n_cmp++;
            if (dut_ctl() !== ctl) begin
                n_fail++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, dut_ctl(), ctl);
            end
            n_cmp++;
            if (bus.o_state !== 2'(m_state) || bus.o_halted !== (m_state == SHalt)) begin
                n_fail++; $display("FAIL rand_state[%0d]: got %0d halted=%b want %0d",
                                   i, bus.o_state, bus.o_halted, m_state);
            end
            n_cmp++;
            if (bus.o_stall_count !== 16'(m_stall) || bus.o_flush_count !== 16'(m_flush)) begin
                n_fail++; $display("FAIL rand_counts[%0d]: got %0d/%0d want %0d/%0d", i,
                                   bus.o_stall_count, bus.o_flush_count, m_stall, m_flush);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_hazard();
        test_branch_vs_hazard();
        test_mem_wait();
        test_reset_mid_wait();
        test_halt_step();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
